byte_bram_pipe: RTL and testbench

Single-clock, true dual-port, byte-write-enable block RAM for the SDSoC trace framework, parametrised in data width, depth, read latency and write mode. Adds a hardware clear engine that zeroes the whole array after reset or on request, a per-port read-valid pipeline, and defined collision rules. Sits under trace adapters as the capture/replay buffer, replacing the uninitialised per-byte BRAMs.

---
 rtl/byte_bram_pkg.sv | 35 +++
 rtl/byte_bram_lane.sv | 111 +++++++++++
 rtl/byte_bram_pipe.sv | 176 +++++++++++++++++
 tb/tb_byte_bram_pipe.sv | 346 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/byte_bram_pkg.sv
// Shared definitions for the byte-write-enable dual-port RAM.
// Holds the write-mode codes, the clear-engine state encoding and the
// constant log2 helpers used to size address fields.
package byte_bram_pkg;

  localparam int unsigned WM_READ_FIRST  = 0;
  localparam int unsigned WM_WRITE_FIRST = 1;
  localparam int unsigned WM_NO_CHANGE   = 2;

  typedef enum logic [0:0] {
    CLR_IDLE  = 1'b0,
    CLR_CLEAR = 1'b1
  } clr_state_t;

  // Floor of log2(v); 0 for v <= 1.
  function automatic int unsigned flogb2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((64'd1 << i) <= 64'(v)) r = 32'(i);
    end
    return r;
  endfunction

  // Ceiling of log2(v); 0 for v <= 1.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(v)) r = 32'(i + 1);
    end
    return r;
  endfunction

endpackage

// File: rtl/byte_bram_lane.sv
// One byte lane of the dual-port RAM: storage, same-port write mode and
// cross-port write priority (port A wins on a shared byte).
// Optional macro BYTE_BRAM_PARITY_EN adds one even-parity bit per entry.
// Ports:
//   aclk, areset        clock and synchronous active-high reset
//   clr_we, clr_idx     clear-engine zero write
//   x_we                commit a write of x_din to x_idx (x = a|b)
//   x_upd               refresh x_dout this cycle
//   x_inr               word index is inside the array
//   x_wsel              raw byte enable, selects new data in write-first mode
//   x_idx, x_din        word index and write byte
//   x_dout, x_perr      registered read byte and parity error
module byte_bram_lane
  import byte_bram_pkg::*;
#(
  parameter int unsigned C_DATA_DEPTH = 1024,
  parameter int unsigned C_WRITE_MODE = 0,
  parameter int unsigned IDX_W        = 10
) (
  input  logic             aclk,
  input  logic             areset,
  input  logic             clr_we,
  input  logic [IDX_W-1:0] clr_idx,
  input  logic             a_we,
  input  logic             a_upd,
  input  logic             a_inr,
  input  logic             a_wsel,
  input  logic [IDX_W-1:0] a_idx,
  input  logic [7:0]       a_din,
  output logic [7:0]       a_dout,
  output logic             a_perr,
  input  logic             b_we,
  input  logic             b_upd,
  input  logic             b_inr,
  input  logic             b_wsel,
  input  logic [IDX_W-1:0] b_idx,
  input  logic [7:0]       b_din,
  output logic [7:0]       b_dout,
  output logic             b_perr
);

`ifdef BYTE_BRAM_PARITY_EN
  localparam int unsigned LW = 9;
  function automatic logic [LW-1:0] enc(input logic [7:0] d);
    return {^d, d};
  endfunction
`else
  localparam int unsigned LW = 8;
  function automatic logic [LW-1:0] enc(input logic [7:0] d);
    return LW'(d);
  endfunction
`endif

  logic [LW-1:0] mem [C_DATA_DEPTH];
  logic [LW-1:0] a_word;
  logic [LW-1:0] b_word;
  logic          a_bad;
  logic          b_bad;

  assign a_word = mem[a_idx];
  assign b_word = mem[b_idx];

`ifdef BYTE_BRAM_PARITY_EN
  assign a_bad = (^a_word[7:0]) != a_word[8];
  assign b_bad = (^b_word[7:0]) != b_word[8];
`else
  assign a_bad = 1'b0;
  assign b_bad = 1'b0;
`endif

  // Later assignments win: port A overrides port B on the same entry.
  always_ff @(posedge aclk) begin : mem_write
    if (clr_we) mem[clr_idx] <= '0;
    if (b_we)   mem[b_idx]   <= enc(b_din);
    if (a_we)   mem[a_idx]   <= enc(a_din);
  end

  // Read registers see the pre-write entry, giving old data across ports.
  always_ff @(posedge aclk) begin : read_regs
    if (areset) begin
      a_dout <= '0;
      a_perr <= 1'b0;
      b_dout <= '0;
      b_perr <= 1'b0;
    end else begin
      a_perr <= 1'b0;
      b_perr <= 1'b0;
      if (a_upd) begin
        if (!a_inr) begin
          a_dout <= '0;
        end else if (C_WRITE_MODE == WM_WRITE_FIRST && a_wsel) begin
          a_dout <= a_din;
        end else begin
          a_dout <= a_word[7:0];
          a_perr <= a_bad;
        end
      end
      if (b_upd) begin
        if (!b_inr) begin
          b_dout <= '0;
        end else if (C_WRITE_MODE == WM_WRITE_FIRST && b_wsel) begin
          b_dout <= b_din;
        end else begin
          b_dout <= b_word[7:0];
          b_perr <= b_bad;
        end
      end
    end
  end

endmodule

// File: rtl/byte_bram_pipe.sv
// True dual-port byte-write-enable RAM with hardware clear engine and
// per-port read-valid pipeline. Optional macro BYTE_BRAM_PARITY_EN enables
// per-byte parity storage; without it a_perr/b_perr stay 0.
// Ports:
//   aclk, areset            clock, synchronous active-high reset
//   clear                   pulse to re-zero the whole array
//   busy                    clear engine running, accesses ignored
//   a_en/a_we/a_addr/a_din  port A access (byte address, byte enables)
//   a_dout/a_rvalid/a_perr  port A read data, valid strobe, parity error
//   b_*                     same for port B
module byte_bram_pipe
  import byte_bram_pkg::*;
#(
  parameter int unsigned C_DATA_WIDTH   = 32,
  parameter int unsigned C_DATA_DEPTH   = 1024,
  parameter int unsigned C_ADDR_WIDTH   = 12,
  parameter int unsigned C_READ_LATENCY = 1,
  parameter int unsigned C_WRITE_MODE   = 0
) (
  input  logic                      aclk,
  input  logic                      areset,
  input  logic                      clear,
  output logic                      busy,
  input  logic                      a_en,
  input  logic [C_DATA_WIDTH/8-1:0] a_we,
  input  logic [C_ADDR_WIDTH-1:0]   a_addr,
  input  logic [C_DATA_WIDTH-1:0]   a_din,
  output logic [C_DATA_WIDTH-1:0]   a_dout,
  output logic                      a_rvalid,
  output logic [C_DATA_WIDTH/8-1:0] a_perr,
  input  logic                      b_en,
  input  logic [C_DATA_WIDTH/8-1:0] b_we,
  input  logic [C_ADDR_WIDTH-1:0]   b_addr,
  input  logic [C_DATA_WIDTH-1:0]   b_din,
  output logic [C_DATA_WIDTH-1:0]   b_dout,
  output logic                      b_rvalid,
  output logic [C_DATA_WIDTH/8-1:0] b_perr
);

  localparam int unsigned NB       = C_DATA_WIDTH / 8;
  localparam int unsigned ADDR_LSB = flogb2(NB);
  localparam int unsigned WA_W     = C_ADDR_WIDTH - ADDR_LSB;
  localparam int unsigned IDX_W    = (clog2(C_DATA_DEPTH) < 1) ? 1 : clog2(C_DATA_DEPTH);

  clr_state_t        state;
  logic [IDX_W-1:0]  clr_cnt;
  logic              clr_we_c;

  // Clear engine: one zero word per cycle from word 0, restarts on reset.
  always_ff @(posedge aclk) begin : clear_fsm
    if (areset) begin
      state   <= CLR_CLEAR;
      clr_cnt <= '0;
      busy    <= 1'b1;
    end else begin
      case (state)
        CLR_CLEAR: begin
          if (clr_cnt == IDX_W'(C_DATA_DEPTH - 1)) begin
            state   <= CLR_IDLE;
            busy    <= 1'b0;
            clr_cnt <= '0;
          end else begin
            clr_cnt <= clr_cnt + IDX_W'(1);
          end
        end
        CLR_IDLE: begin
          if (clear) begin
            state   <= CLR_CLEAR;
            busy    <= 1'b1;
            clr_cnt <= '0;
          end
        end
        default: state <= CLR_IDLE;
      endcase
    end
  end

  assign clr_we_c = (state == CLR_CLEAR);

  // Address decode and access qualification.
  logic [WA_W-1:0]  a_waddr, b_waddr;
  logic [IDX_W-1:0] a_idx, b_idx;
  logic             a_inr, b_inr;
  logic             a_acc, b_acc;
  logic             a_upd, b_upd;

  assign a_waddr = a_addr[C_ADDR_WIDTH-1:ADDR_LSB];
  assign b_waddr = b_addr[C_ADDR_WIDTH-1:ADDR_LSB];
  assign a_idx   = IDX_W'(a_waddr);
  assign b_idx   = IDX_W'(b_waddr);
  assign a_inr   = 32'(a_waddr) < C_DATA_DEPTH;
  assign b_inr   = 32'(b_waddr) < C_DATA_DEPTH;
  assign a_acc   = a_en && !busy;
  assign b_acc   = b_en && !busy;
  // No-change mode keeps the read register frozen on any write.
  assign a_upd   = a_acc && !((C_WRITE_MODE == WM_NO_CHANGE) && (|a_we));
  assign b_upd   = b_acc && !((C_WRITE_MODE == WM_NO_CHANGE) && (|b_we));

  if (ADDR_LSB > 0) begin : g_lsb
    logic unused_lsb;
    assign unused_lsb = ^{a_addr[ADDR_LSB-1:0], b_addr[ADDR_LSB-1:0]};
  end

  logic [C_DATA_WIDTH-1:0] a_d1, b_d1;
  logic [NB-1:0]           a_p1, b_p1;
  logic                    a_v1, b_v1;

  for (genvar i = 0; i < NB; i++) begin : g_lane
    byte_bram_lane #(
      .C_DATA_DEPTH (C_DATA_DEPTH),
      .C_WRITE_MODE (C_WRITE_MODE),
      .IDX_W        (IDX_W)
    ) u_lane (
      .aclk    (aclk),
      .areset  (areset),
      .clr_we  (clr_we_c),
      .clr_idx (clr_cnt),
      .a_we    (a_acc && a_inr && a_we[i]),
      .a_upd   (a_upd),
      .a_inr   (a_inr),
      .a_wsel  (a_we[i]),
      .a_idx   (a_idx),
      .a_din   (a_din[8*i +: 8]),
      .a_dout  (a_d1[8*i +: 8]),
      .a_perr  (a_p1[i]),
      .b_we    (b_acc && b_inr && b_we[i]),
      .b_upd   (b_upd),
      .b_inr   (b_inr),
      .b_wsel  (b_we[i]),
      .b_idx   (b_idx),
      .b_din   (b_din[8*i +: 8]),
      .b_dout  (b_d1[8*i +: 8]),
      .b_perr  (b_p1[i])
    );
  end

  // First valid stage, aligned with the lane read registers.
  always_ff @(posedge aclk) begin : valid_s1
    if (areset) begin
      a_v1 <= 1'b0;
      b_v1 <= 1'b0;
    end else begin
      a_v1 <= a_acc;
      b_v1 <= b_acc;
    end
  end

  if (C_READ_LATENCY == 1) begin : g_lat1
    assign a_dout   = a_d1;
    assign a_rvalid = a_v1;
    assign a_perr   = a_p1;
    assign b_dout   = b_d1;
    assign b_rvalid = b_v1;
    assign b_perr   = b_p1;
  end else begin : g_lat2
    // Extra output stage; data only reloads on a valid beat.
    always_ff @(posedge aclk) begin : out_stage
      if (areset) begin
        a_dout   <= '0;
        a_rvalid <= 1'b0;
        a_perr   <= '0;
        b_dout   <= '0;
        b_rvalid <= 1'b0;
        b_perr   <= '0;
      end else begin
        a_rvalid <= a_v1;
        b_rvalid <= b_v1;
        a_perr   <= a_v1 ? a_p1 : '0;
        b_perr   <= b_v1 ? b_p1 : '0;
        if (a_v1) a_dout <= a_d1;
        if (b_v1) b_dout <= b_d1;
      end
    end
  end

endmodule

// File: tb/tb_byte_bram_pipe.sv
// Bench for byte_bram_pipe: three instances (read-first/lat1,
// write-first/lat2, no-change/lat1) share one stimulus stream and are
// checked each cycle against a word-level array model.
module tb_byte_bram_pipe;

  localparam int DEPTH  = 1024;
  localparam int ADDR_W = 13;
  localparam int LAT_M  [3] = '{1, 2, 1};
  localparam int MODE_M [3] = '{0, 1, 2};

  logic              aclk = 1'b0;
  logic              areset;
  logic              clear;
  logic              a_en, b_en;
  logic [3:0]        a_we, b_we;
  logic [ADDR_W-1:0] a_addr, b_addr;
  logic [31:0]       a_din, b_din;

  logic        busy_w [3];
  logic [31:0] dout_w [3][2];
  logic        rv_w   [3][2];
  logic [3:0]  perr_w [3][2];

  always #5 aclk = ~aclk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    byte_bram_pipe #(
      .C_DATA_WIDTH   (32),
      .C_DATA_DEPTH   (DEPTH),
      .C_ADDR_WIDTH   (ADDR_W),
      .C_READ_LATENCY ((g == 1) ? 2 : 1),
      .C_WRITE_MODE   (g)
    ) u_dut (
      .aclk     (aclk),
      .areset   (areset),
      .clear    (clear),
      .busy     (busy_w[g]),
      .a_en     (a_en),
      .a_we     (a_we),
      .a_addr   (a_addr),
      .a_din    (a_din),
      .a_dout   (dout_w[g][0]),
      .a_rvalid (rv_w[g][0]),
      .a_perr   (perr_w[g][0]),
      .b_en     (b_en),
      .b_we     (b_we),
      .b_addr   (b_addr),
      .b_din    (b_din),
      .b_dout   (dout_w[g][1]),
      .b_rvalid (rv_w[g][1]),
      .b_perr   (perr_w[g][1])
    );
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic cmp(input string name, input int d, input int p,
                     input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s dut%0d port%0d: got %h expected %h at %0t", name, d, p, got, exp, $time);
    end
  endtask

  task automatic lit(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n,
                                        input logic [3:0] we);
    logic [31:0] r;
    r = o;
    for (int i = 0; i < 4; i++) if (we[i]) r[8*i +: 8] = n[8*i +: 8];
    return r;
  endfunction

  // Word-level model of the array, clear timing and per-instance read beats.
  logic [31:0] mem_m  [DEPTH];
  logic        busy_m = 1'b0;
  int          busy_rem;
  int          cyc = 0;
  logic        model_ready = 1'b0;
  logic        chk_en = 1'b1;
  logic        exp_v   [3][2];
  logic [31:0] exp_d   [3][2];
  logic [31:0] last_m  [3][2];
  logic        sched_v [3][2][4];
  logic [31:0] sched_d [3][2][4];

  always @(posedge aclk) begin : model
    logic        en_p  [2];
    logic [3:0]  we_p  [2];
    logic [31:0] din_p [2];
    logic [31:0] old_p [2];
    logic        inr_p [2];
    int          w_p   [2];
    logic [31:0] rd;
    int          slot;
    en_p[0] = a_en;  we_p[0] = a_we;  din_p[0] = a_din;  w_p[0] = int'(a_addr >> 2);
    en_p[1] = b_en;  we_p[1] = b_we;  din_p[1] = b_din;  w_p[1] = int'(b_addr >> 2);
    cyc = cyc + 1;
    if (areset) begin
      model_ready = 1'b1;
      busy_m      = 1'b1;
      busy_rem    = DEPTH;
      for (int i = 0; i < DEPTH; i++) mem_m[i] = '0;
      for (int d = 0; d < 3; d++)
        for (int p = 0; p < 2; p++) begin
          exp_v[d][p]  = 1'b0;
          exp_d[d][p]  = '0;
          last_m[d][p] = '0;
          for (int s = 0; s < 4; s++) sched_v[d][p][s] = 1'b0;
        end
    end else begin
      if (!busy_m) begin
        for (int p = 0; p < 2; p++) begin
          inr_p[p] = w_p[p] < DEPTH;
          old_p[p] = inr_p[p] ? mem_m[w_p[p]] : 32'h0;
        end
        for (int p = 0; p < 2; p++) begin
          if (en_p[p]) begin
            for (int d = 0; d < 3; d++) begin
              case (MODE_M[d])
                0:       rd = old_p[p];
                1:       rd = inr_p[p] ? merge(old_p[p], din_p[p], we_p[p]) : 32'h0;
                default: rd = (we_p[p] != 4'h0) ? last_m[d][p] : old_p[p];
              endcase
              last_m[d][p] = rd;
              slot = (cyc + LAT_M[d] - 1) % 4;
              sched_v[d][p][slot] = 1'b1;
              sched_d[d][p][slot] = rd;
            end
          end
        end
        if (en_p[1] && inr_p[1]) mem_m[w_p[1]] = merge(mem_m[w_p[1]], din_p[1], we_p[1]);
        if (en_p[0] && inr_p[0]) mem_m[w_p[0]] = merge(mem_m[w_p[0]], din_p[0], we_p[0]);
      end
      if (busy_m) begin
        busy_rem = busy_rem - 1;
        if (busy_rem == 0) busy_m = 1'b0;
      end else if (clear) begin
        busy_m   = 1'b1;
        busy_rem = DEPTH;
        for (int i = 0; i < DEPTH; i++) mem_m[i] = '0;
      end
      slot = cyc % 4;
      for (int d = 0; d < 3; d++)
        for (int p = 0; p < 2; p++) begin
          exp_v[d][p] = sched_v[d][p][slot];
          if (sched_v[d][p][slot]) exp_d[d][p] = sched_d[d][p][slot];
          sched_v[d][p][slot] = 1'b0;
        end
    end
  end

  always @(negedge aclk) begin : compare
    if (model_ready && chk_en) begin
      for (int d = 0; d < 3; d++) begin
        cmp("busy", d, 0, 32'(busy_w[d]), 32'(busy_m));
        for (int p = 0; p < 2; p++) begin
          cmp("rvalid", d, p, 32'(rv_w[d][p]), 32'(exp_v[d][p]));
          cmp("dout",   d, p, dout_w[d][p], exp_d[d][p]);
          cmp("perr",   d, p, 32'(perr_w[d][p]), 32'h0);
        end
      end
    end
  end

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic drv(input logic ae, input logic [3:0] awe, input logic [ADDR_W-1:0] aad,
                     input logic [31:0] ad, input logic be, input logic [3:0] bwe,
                     input logic [ADDR_W-1:0] bad, input logic [31:0] bd);
    a_en = ae;  a_we = awe;  a_addr = aad;  a_din = ad;
    b_en = be;  b_we = bwe;  b_addr = bad;  b_din = bd;
  endtask

  task automatic idle();
    drv(1'b0, 4'h0, '0, '0, 1'b0, 4'h0, '0, '0);
  endtask

  task automatic wait_busy(output int n, output int rv);
    n  = 0;
    rv = 0;
    while (busy_w[0] && n < 5000) begin
      tick();
      n++;
      if (rv_w[0][0]) rv++;
    end
  endtask

  function automatic logic [ADDR_W-1:0] rnd_addr();
    int unsigned w;
    if ($urandom_range(0, 9) == 0) w = 1024 + $urandom_range(0, 1023);
    else                           w = $urandom_range(0, 7);
    return ADDR_W'(w * 4 + $urandom_range(0, 3));
  endfunction

  initial begin : stim
    int n, rv, nz, beats;
    areset = 1'b1;
    clear  = 1'b0;
    idle();
    repeat (3) @(posedge aclk);
    #1;
    areset = 1'b0;
    a_en   = 1'b1;
    wait_busy(n, rv);
    lit("busy_len_after_reset", 32'(n), 32'd1024);
    lit("no_rvalid_while_busy", 32'(rv), 32'd0);

    // Read word 5 of the freshly cleared array.
    drv(1'b1, 4'h0, 13'h014, '0, 1'b0, 4'h0, '0, '0);
    tick();
    lit("read_w5_zero", dout_w[0][0], 32'h0);
    lit("read_w5_rvalid", 32'(rv_w[0][0]), 32'd1);

    // Partial byte write then read back.
    drv(1'b1, 4'b0101, 13'h010, 32'hDEADBEEF, 1'b0, 4'h0, '0, '0);
    tick();
    drv(1'b1, 4'h0, 13'h010, '0, 1'b0, 4'h0, '0, '0);
    tick();
    lit("byte_merge", dout_w[0][0], 32'h00AD00EF);

    // Same-port read-during-write in the three write modes.
    drv(1'b1, 4'hF, 13'h020, 32'h11223344, 1'b0, 4'h0, '0, '0);
    tick();
    drv(1'b1, 4'h0, 13'h010, '0, 1'b0, 4'h0, '0, '0);
    tick();
    drv(1'b1, 4'hF, 13'h020, 32'hAABBCCDD, 1'b0, 4'h0, '0, '0);
    tick();
    lit("read_first_old", dout_w[0][0], 32'h11223344);
    lit("no_change_hold", dout_w[2][0], 32'h00AD00EF);
    lit("no_change_rvalid", 32'(rv_w[2][0]), 32'd1);
    idle();
    tick();
    lit("write_first_new", dout_w[1][0], 32'hAABBCCDD);
    lit("write_first_rvalid", 32'(rv_w[1][0]), 32'd1);

    // Cross-port collision on the same byte.
    drv(1'b1, 4'b0001, 13'h024, 32'h000000AA, 1'b1, 4'b0001, 13'h024, 32'h000000BB);
    tick();
    drv(1'b1, 4'h0, 13'h024, '0, 1'b1, 4'h0, 13'h024, '0);
    tick();
    lit("collide_a_wins_a", dout_w[0][0], 32'h000000AA);
    lit("collide_a_wins_b", dout_w[0][1], 32'h000000AA);

    // Latency-2 back-to-back reads of words 1..3.
    drv(1'b1, 4'hF, 13'h004, 32'h10000001, 1'b1, 4'hF, 13'h008, 32'h20000002);
    tick();
    drv(1'b1, 4'hF, 13'h00C, 32'h30000003, 1'b0, 4'h0, '0, '0);
    tick();
    idle();
    tick();
    tick();
    drv(1'b1, 4'h0, 13'h004, '0, 1'b0, 4'h0, '0, '0);
    tick();
    lit("lat2_not_yet", 32'(rv_w[1][0]), 32'd0);
    drv(1'b1, 4'h0, 13'h008, '0, 1'b0, 4'h0, '0, '0);
    tick();
    lit("lat2_beat1", dout_w[1][0], 32'h10000001);
    lit("lat2_beat1_v", 32'(rv_w[1][0]), 32'd1);
    drv(1'b1, 4'h0, 13'h00C, '0, 1'b0, 4'h0, '0, '0);
    tick();
    lit("lat2_beat2", dout_w[1][0], 32'h20000002);
    idle();
    tick();
    lit("lat2_beat3", dout_w[1][0], 32'h30000003);
    lit("lat2_beat3_v", 32'(rv_w[1][0]), 32'd1);
    tick();
    lit("lat2_done", 32'(rv_w[1][0]), 32'd0);

    // Random traffic with collisions, out-of-range words and rare clears.
    for (int k = 0; k < 2500; k++) begin
      drv($urandom_range(0, 3) != 0, ($urandom_range(0, 1) != 0) ? 4'($urandom) : 4'h0,
          rnd_addr(), $urandom,
          $urandom_range(0, 3) != 0, ($urandom_range(0, 1) != 0) ? 4'($urandom) : 4'h0,
          rnd_addr(), $urandom);
      clear = ($urandom_range(0, 799) == 0);
      tick();
    end
    clear = 1'b0;
    idle();
    wait_busy(n, rv);

    // Clear request, then reset ten cycles into it.
    drv(1'b1, 4'hF, 13'h1FFC, 32'hCAFEF00D, 1'b1, 4'hF, 13'h0FFC, 32'h5A5A5A5A);
    tick();
    idle();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    lit("clear_busy", 32'(busy_w[0]), 32'd1);
    repeat (10) tick();
    areset = 1'b1;
    tick();
    lit("reset_mid_clear_busy", 32'(busy_w[0]), 32'd1);
    areset = 1'b0;
    wait_busy(n, rv);
    lit("restart_clear_len", 32'(n), 32'd1024);

    // Sweep the whole array on both ports.
    nz    = 0;
    beats = 0;
    for (int i = 0; i <= 512; i++) begin
      if (i < 512) drv(1'b1, 4'h0, ADDR_W'(i * 4), '0, 1'b1, 4'h0, ADDR_W'((i + 512) * 4), '0);
      else         idle();
      tick();
      for (int p = 0; p < 2; p++) begin
        if (rv_w[0][p]) begin
          beats++;
          if (dout_w[0][p] != 32'h0) nz++;
        end
      end
    end
    lit("sweep_nonzero", 32'(nz), 32'd0);
    lit("sweep_beats", 32'(beats), 32'd1024);

`ifdef BYTE_BRAM_PARITY_EN
    chk_en = 1'b0;
    drv(1'b1, 4'hF, 13'h018, 32'h12345678, 1'b0, 4'h0, '0, '0);
    tick();
    idle();
    tick();
    g_dut[0].u_dut.g_lane[2].u_lane.mem[6][0] = ~g_dut[0].u_dut.g_lane[2].u_lane.mem[6][0];
    drv(1'b1, 4'h0, 13'h018, '0, 1'b0, 4'h0, '0, '0);
    tick();
    lit("parity_flip_lane2", 32'(perr_w[0][0]), 32'h4);
    idle();
`endif

    tick();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
